// File: rtl/mpsoc_spram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among several requesters.
// Optional per-port lock keeps ownership across back-to-back bursts.
module mpsoc_spram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int PTR_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS-1:0]             lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [BE_WIDTH-1:0]              mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [PTR_WIDTH-1:0] owner_q, owner_d;
  logic                 owner_vld_q, owner_vld_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [PTR_WIDTH-1:0] sel;
  logic [PTR_WIDTH-1:0] kp;
  logic                 sel_vld;
  int                   k;

  // Locked owner wins; otherwise scan from ptr_q with modulo wrap
  always_comb begin
    sel     = owner_q;
    sel_vld = 1'b0;
    k       = 0;
    kp      = '0;
    if (owner_vld_q && req_i[owner_q]) begin
      sel_vld = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        k = int'(ptr_q) + i;
        if (k >= NUM_PORTS) k = k - NUM_PORTS;
        kp = PTR_WIDTH'(k);
        if (!sel_vld && req_i[kp]) begin
          sel     = kp;
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (sel_vld) begin
      gnt_o       = NUM_PORTS'(1) << sel;
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[sel];
      mem_addr_o  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_be_o    = be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
      mem_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q & req_i[owner_q];
    if (sel_vld) begin
      if (lock_i[sel]) begin
        owner_d     = sel;
        owner_vld_d = 1'b1;
      end else begin
        owner_vld_d = 1'b0;
        if (int'(sel) == NUM_PORTS - 1) ptr_d = '0;
        else ptr_d = sel + 1'b1;
      end
    end
    rvalid_d = gnt_o & ~{NUM_PORTS{mem_we_o}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      rvalid_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mpsoc_spram_arbiter.sv
// Bench for mpsoc_spram_arbiter: directed scenarios plus randomized
// traffic against a queue-free behavioural arbiter and SRAM model.
module tb_mpsoc_spram_arbiter;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [3:0]   req = '0, we = '0, lock = '0;
  logic [255:0] addr = '0, wdata = '0;
  logic [31:0]  be = '0;
  logic [3:0]   gnt, rvalid;
  logic [63:0]  rdata, mem_addr, mem_wdata;
  logic [63:0]  mem_rdata = '0;
  logic         mem_req, mem_we;
  logic [7:0]   mem_be;

  logic [2:0]   req3 = '0, we3 = '0, lock3 = '0;
  logic [191:0] addr3 = '0, wdata3 = '0;
  logic [23:0]  be3 = '0;
  logic [2:0]   gnt3, rvalid3;
  logic [63:0]  rdata3, mem3_addr, mem3_wdata;
  logic [63:0]  mem3_rdata = '0;
  logic         mem3_req, mem3_we;
  logic [7:0]   mem3_be;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mpsoc_spram_arbiter u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  mpsoc_spram_arbiter #(.NUM_PORTS(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_i(req3), .we_i(we3), .lock_i(lock3),
    .addr_i(addr3), .be_i(be3), .wdata_i(wdata3),
    .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .mem_req_o(mem3_req), .mem_we_o(mem3_we),
    .mem_addr_o(mem3_addr), .mem_be_o(mem3_be),
    .mem_wdata_o(mem3_wdata), .mem_rdata_i(mem3_rdata)
  );

  // SRAM macro stand-in driven by the DUT's memory port
  logic [63:0] sram [16];
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) sram[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b])
            sram[mem_addr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[6:3]];
      end
    end
  end

  // Reference model state
  int          m_ptr, m_own, m_rvp;
  logic [63:0] m_rvd;
  logic [63:0] ref_mem [16];

  task automatic model_reset();
    m_ptr = 0;
    m_own = -1;
    m_rvp = -1;
    m_rvd = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  function automatic int pick();
    if (m_own >= 0 && req[m_own]) return m_own;
    for (int i = 0; i < 4; i++)
      if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    return -1;
  endfunction

  task automatic model_commit(input int g);
    logic [63:0] a;
    int ix;
    m_rvp = -1;
    if (g >= 0) begin
      a  = addr[g*64 +: 64];
      ix = int'(a[6:3]);
      if (we[g]) begin
        for (int b = 0; b < 8; b++)
          if (be[g*8+b])
            ref_mem[ix][b*8 +: 8] = wdata[g*64 + b*8 +: 8];
      end else begin
        m_rvp = g;
        m_rvd = ref_mem[ix];
      end
      if (lock[g]) m_own = g;
      else begin
        m_own = -1;
        m_ptr = (g + 1) % 4;
      end
    end else begin
      m_own = -1;
    end
  endtask

  task automatic tick();
    int g;
    g = pick();
    @(posedge clk);
    model_commit(g);
    #1;
  endtask

  task automatic do_reset();
    req = '0; we = '0; lock = '0;
    req3 = '0; we3 = '0; lock3 = '0;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    total++;
    if (rvalid !== 4'b0 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL reset_out rvalid=%b gnt=%b exp=0", rvalid, gnt);
    end
    total++;
    if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin
      bad++;
      $display("FAIL reset_mem req=%b addr=%h exp=0", mem_req, mem_addr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || rvalid !== 4'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle gnt=%b rv=%b we=%b exp=0", gnt, rvalid, mem_we);
    end
    tick();
  endtask

  task automatic test_rr_reads();
    logic [3:0] eg, erv;
    for (int p = 0; p < 4; p++) addr[p*64 +: 64] = 64'(p * 8);
    we = '0; lock = '0;
    for (int c = 0; c < 6; c++) begin
      req = (c < 5) ? 4'hF : 4'h0;
      eg  = (c < 5) ? 4'(1 << (c % 4)) : 4'h0;
      erv = (c > 0) ? 4'(1 << ((c - 1) % 4)) : 4'h0;
      @(negedge clk);
      total++;
      if (gnt !== eg) begin
        bad++;
        $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg);
      end
      total++;
      if (rvalid !== erv) begin
        bad++;
        $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, rvalid, erv);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    req = 4'b0100; we = 4'b0100; lock = '0;
    addr[128 +: 64]  = 64'h40;
    be[16 +: 8]      = 8'hFF;
    wdata[128 +: 64] = 64'hDEADBEEF;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || mem_we !== 1'b1) begin
      bad++;
      $display("FAIL wr_gnt gnt=%b we=%b exp=0100/1", gnt, mem_we);
    end
    total++;
    if (mem_addr !== 64'h40 || mem_be !== 8'hFF ||
        mem_wdata !== 64'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_bus a=%h be=%h d=%h", mem_addr, mem_be, mem_wdata);
    end
    tick();
    we = 4'b0000;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100 || mem_we !== 1'b0 || rvalid !== 4'b0) begin
      bad++;
      $display("FAIL rd_gnt gnt=%b we=%b rv=%b", gnt, mem_we, rvalid);
    end
    tick();
    req = '0;
    @(negedge clk);
    total++;
    if (rvalid !== 4'b0100 || rdata !== 64'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_data rv=%b d=%h exp=0100/deadbeef", rvalid, rdata);
    end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b1010; lock = 4'b0010; we = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0010) begin
        bad++;
        $display("FAIL lock_gnt c=%0d got=%b exp=0010", c, gnt);
      end
      total++;
      if (rvalid !== ((c > 0) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL lock_rv c=%0d got=%b", c, rvalid);
      end
      tick();
    end
    req = 4'b1000; lock = '0;
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL lock_release got=%b exp=1000", gnt);
    end
    tick();
    req = 4'hF;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL lock_ptr_wrap got=%b exp=0001", gnt);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_reset_midread();
    we = '0; lock = '0;
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0100) begin
      bad++;
      $display("FAIL mr_gnt2 got=%b exp=0100", gnt);
    end
    tick();
    req = 4'b1000;
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000 || rvalid !== 4'b0100) begin
      bad++;
      $display("FAIL mr_gnt3 gnt=%b rv=%b exp=1000/0100", gnt, rvalid);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (rvalid !== 4'b0) begin
      bad++;
      $display("FAIL mr_async_clear rv=%b exp=0000", rvalid);
    end
    req = '0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (rvalid !== 4'b0) begin
      bad++;
      $display("FAIL mr_dropped rv=%b exp=0000", rvalid);
    end
    tick();
    req = 4'b0011;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL mr_ptr0 got=%b exp=0001", gnt);
    end
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_n3_wrap();
    do_reset();
    addr3 = {64'h3000, 64'h2000, 64'h1000};
    req3 = 3'b100;
    @(negedge clk);
    total++;
    if (gnt3 !== 3'b100 || mem3_addr !== 64'h3000 || !mem3_req) begin
      bad++;
      $display("FAIL n3_p2 gnt=%b a=%h exp=100/3000", gnt3, mem3_addr);
    end
    @(posedge clk);
    #1;
    req3 = 3'b101;
    @(negedge clk);
    total++;
    if (gnt3 !== 3'b001 || rvalid3 !== 3'b100) begin
      bad++;
      $display("FAIL n3_wrap gnt=%b rv=%b exp=001/100", gnt3, rvalid3);
    end
    @(posedge clk);
    #1;
    req3 = 3'b110;
    @(negedge clk);
    total++;
    if (gnt3 !== 3'b010 || mem3_addr !== 64'h2000) begin
      bad++;
      $display("FAIL n3_next gnt=%b a=%h exp=010/2000", gnt3, mem3_addr);
    end
    @(posedge clk);
    #1;
    req3 = '0;
    do_reset();
  endtask

  task automatic test_random();
    logic [3:0] pend = '0;
    logic [3:0] eg;
    logic [63:0] ea, ed;
    logic [7:0] eb;
    logic ew;
    int g;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 5) begin
          pend[p] = 1'b1;
          we[p]   = 1'($urandom_range(0, 1));
          lock[p] = ($urandom_range(0, 3) == 0);
          addr[p*64 +: 64]  = {$urandom, $urandom};
          be[p*8 +: 8]      = 8'($urandom);
          wdata[p*64 +: 64] = {$urandom, $urandom};
        end
      end
      req = pend;
      g  = pick();
      eg = (g >= 0) ? 4'(1 << g) : 4'h0;
      ew = (g >= 0) ? we[g] : 1'b0;
      ea = (g >= 0) ? addr[g*64 +: 64] : 64'h0;
      eb = (g >= 0) ? be[g*8 +: 8] : 8'h0;
      ed = (g >= 0) ? wdata[g*64 +: 64] : 64'h0;
      @(negedge clk);
      total++;
      if (gnt !== eg || mem_req !== (g >= 0) || mem_we !== ew) begin
        bad++;
        $display("FAIL rnd_gnt cyc=%0d gnt=%b exp=%b we=%b exp=%b",
                 cyc, gnt, eg, mem_we, ew);
      end
      total++;
      if (mem_addr !== ea || mem_be !== eb || mem_wdata !== ed) begin
        bad++;
        $display("FAIL rnd_bus cyc=%0d a=%h/%h be=%h/%h d=%h/%h",
                 cyc, mem_addr, ea, mem_be, eb, mem_wdata, ed);
      end
      total++;
      if (rvalid !== ((m_rvp >= 0) ? 4'(1 << m_rvp) : 4'h0)) begin
        bad++;
        $display("FAIL rnd_rvalid cyc=%0d got=%b exp_port=%0d",
                 cyc, rvalid, m_rvp);
      end
      if (m_rvp >= 0) begin
        total++;
        if (rdata !== m_rvd) begin
          bad++;
          $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata, m_rvd);
        end
      end
      @(posedge clk);
      model_commit(g);
      if (g >= 0) pend[g] = 1'b0;
      #1;
    end
    req = '0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_reads();
    test_write_read();
    test_lock();
    test_reset_midread();
    test_n3_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpsoc_spram_arbiter.md
# mpsoc_spram_arbiter

Round-robin arbiter that shares one single-port SRAM macro among NUM_PORTS requesters (e.g. the AXI4 SRAM bridge, a debug/DMA loader and a core-local port). It accepts at most one access per cycle, drives the SRAM request/write/address/byte-enable/data signals, and returns read data with a registered per-port valid strobe one cycle after grant. An optional per-port lock holds ownership for back-to-back bursts.

## Interface
- NUM_PORTS, 4: number of requesters, ≥2.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 64: data width, multiple of 8. BE_WIDTH = DATA_WIDTH/8, PTR_WIDTH = $clog2(NUM_PORTS).

- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- req_i  in  NUM_PORTS  per-port access request.
- we_i  in  NUM_PORTS  per-port write enable; 0 means read.
- lock_i  in  NUM_PORTS  keep ownership after this grant.
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address, port k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- be_i  in  NUM_PORTS*BE_WIDTH  per-port byte enables.
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- gnt_o  out  NUM_PORTS  one-hot grant, combinational, same cycle as access.
- rvalid_o  out  NUM_PORTS  read data valid for port k, registered.
- rdata_o  out  DATA_WIDTH  shared read data, equals mem_rdata_i.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_be_o  out  BE_WIDTH  SRAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read request.

## Operation
- State: ptr_q (PTR_WIDTH), owner_q (PTR_WIDTH), owner_vld_q (1), rvalid_q (NUM_PORTS).
- Selection each cycle:
  - If owner_vld_q and req_i[owner_q], grant owner_q.
  - Otherwise grant the first k with req_i[k], scanning ptr_q, ptr_q+1, … modulo NUM_PORTS.
  - With no request, there is no grant.
- A locked owner that drops req_i releases the lock. The same cycle falls through to normal round-robin.
- On grant of port k:
  - gnt_o = 1<<k.
  - mem_req_o = 1. mem_we_o = we_i[k].
  - mem_addr_o, mem_be_o and mem_wdata_o come from slice k.
- No grant: all mem_* outputs and gnt_o are 0.
- Next-state update after a grant to k:
  - If lock_i[k]: owner_q ← k, owner_vld_q ← 1, ptr_q unchanged.
  - Else: owner_vld_q ← 0, ptr_q ← (k+1) mod NUM_PORTS. Wrap from NUM_PORTS-1 goes to 0, including non-power-of-two NUM_PORTS.
- No grant: ptr_q is held. owner_vld_q ← 0 only if the owner's request dropped.
- rvalid_q ← gnt_o & ~{NUM_PORTS{mem_we_o}} every cycle.
  - Writes complete at grant and produce no rvalid.
  - rvalid_o = rvalid_q. rdata_o = mem_rdata_i, meaningful only while some rvalid_o bit is set.
- Requesters must hold req/we/addr/be/wdata stable until granted. The arbiter does not buffer them.

## Timing
- Reset values: ptr_q=0, owner_vld_q=0, owner_q=0, rvalid_o=0. gnt_o and mem_* are 0 while all req_i=0.
- Grant latency is 0 cycles: combinational from req_i, ptr_q and owner state.
- Read data latency: data is returned 1 cycle after grant, with rvalid_o[k] high for exactly 1 cycle per granted read.
- Throughput: 1 access per cycle, back-to-back, with no bubbles between ports.
- Fairness: a continuously requesting unlocked port waits at most NUM_PORTS-1 grants. A locked owner can starve others for as long as it keeps req_i and lock_i high, and this is by design.
- Simultaneous events:
  - Read grant in cycle n and a new grant in n+1: rvalid for the cycle-n read still appears in n+1, alongside the new gnt_o.
  - Lock asserted on a write behaves identically to a lock asserted on a read.
- Reset mid-operation clears rvalid_q immediately and asynchronously. A read in flight is dropped, with no rvalid after reset release.

## Test plan
- Reset, then all four ports issue read requests continuously with NUM_PORTS=4 → grants 0,1,2,3,0 on consecutive cycles. rvalid_o = 0001, 0010, 0100, 1000, each one cycle after the matching grant.
- Port 2 write (addr 0x40, be 0xFF, data 0xDEADBEEF) then port 2 read at 0x40 → mem_we_o=1, then 0. rvalid_o[2]=1 in the cycle after the read grant with rdata_o=0xDEADBEEF. No rvalid for the write.
- Ports 1 and 3 requesting, port 1 with lock_i=1 for 3 grants → port 1 granted 3 consecutive cycles. After lock/req drop, port 3 granted next cycle, then ptr_q=0.
- NUM_PORTS=3, only port 2 requesting → granted. Next, ports 0 and 2 requesting → port 0 granted, confirming the pointer wrapped 2→0.
- Read granted, then rst_ni pulsed low before the next edge → rvalid_o stays 0 and ptr_q=0. After release, the first request from port 1 with port 0 also requesting grants port 0.
